// File: rtl/hc4_ram_arbiter_if.sv
// hc4_ram_arbiter_if: RAM-side bus bundle for the HC4 data RAM arbiter.
// Groups the core port, the DMA req/ack port and the physical RAM pins.
// slave  = arbiter view, master = environment (core, DMA requester, RAM).
interface hc4_ram_arbiter_if;
    // core port
    logic [7:0] cpu_addr;
    logic [3:0] cpu_wdata;
    logic       cpu_rd;
    logic       cpu_wr;
    logic [3:0] cpu_rdata;
    logic       cpu_clk_en;
    // DMA port
    logic       dma_req;
    logic       dma_we;
    logic [7:0] dma_addr;
    logic [3:0] dma_wdata;
    logic       dma_ack;
    logic [3:0] dma_rdata;
    logic       dma_starve;
    // physical RAM
    logic [7:0] ram_addr;
    logic [3:0] ram_wdata;
    logic [3:0] ram_rdata;
    logic       ram_nrd;
    logic       ram_nwr;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  ram_rdata,
        output cpu_rdata, cpu_clk_en,
        output dma_ack, dma_rdata, dma_starve,
        output ram_addr, ram_wdata, ram_nrd, ram_nwr
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output ram_rdata,
        input  cpu_rdata, cpu_clk_en,
        input  dma_ack, dma_rdata, dma_starve,
        input  ram_addr, ram_wdata, ram_nrd, ram_nwr
    );
endinterface

// File: rtl/hc4_ram_arbiter.sv
// hc4_ram_arbiter: shares the HC4 256x4 data RAM between the core and a
// DMA/loader port. The core owns the RAM by default; a DMA access takes one
// S_DMA cycle followed by an S_ACK cycle. A core that needs RAM during S_DMA
// is held with cpu_clk_en = 0. RAM strobes are only active in clk-low half.
// Optional macro HC4_ARB_FAIR_EN: starve counter that forces DMA through
// after STARVE_LIMIT consecutive denied request cycles. Without it the core
// has strict priority.
module hc4_ram_arbiter #(
    parameter int STARVE_LIMIT = 4   // 1..15, fair mode only
) (
    input  logic                clk,
    input  logic                nReset,
    hc4_ram_arbiter_if.slave    bus
);
    localparam logic [1:0] S_CPU = 2'd0;
    localparam logic [1:0] S_DMA = 2'd1;
    localparam logic [1:0] S_ACK = 2'd2;

    logic [1:0] state, state_nxt;
    logic       core_acc;
    logic       starve;
    logic       rd_sel, wr_sel;
    logic       dma_own;

    assign core_acc = bus.cpu_rd | bus.cpu_wr;
    assign dma_own  = (state == S_DMA);

`ifdef HC4_ARB_FAIR_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt;

    assign starve = (starve_cnt == LIMIT) & bus.dma_req & (state == S_CPU);

    // count denied request cycles; cleared when DMA is granted or withdraws
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset)
            starve_cnt <= 4'd0;
        else if (!bus.dma_req || (state == S_CPU && state_nxt == S_DMA))
            starve_cnt <= 4'd0;
        else if (state == S_CPU && core_acc && starve_cnt != LIMIT)
            starve_cnt <= starve_cnt + 4'd1;
    end
`else
    // strict core priority: the limit has no meaning here
    logic unused_starve_limit;
    assign unused_starve_limit = ^4'(STARVE_LIMIT);
    assign starve = 1'b0;
`endif

    // next state: DMA is granted when the core leaves the RAM alone or is starved out
    always_comb begin
        state_nxt = state;
        case (state)
            S_CPU:   if (bus.dma_req && (!core_acc || starve)) state_nxt = S_DMA;
            S_DMA:   state_nxt = S_ACK;
            S_ACK:   state_nxt = S_CPU;
            default: state_nxt = S_CPU;
        endcase
    end

    // state register; reset abandons any in-flight DMA access without ack
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) state <= S_CPU;
        else         state <= state_nxt;
    end

    // RAM port mux and core clock enable; write wins over a simultaneous core read
    always_comb begin
        bus.ram_addr   = bus.cpu_addr;
        bus.ram_wdata  = bus.cpu_wdata;
        wr_sel         = bus.cpu_wr & ~starve;
        rd_sel         = bus.cpu_rd & ~bus.cpu_wr & ~starve;
        bus.cpu_clk_en = ~starve;
        if (dma_own) begin
            bus.ram_addr   = bus.dma_addr;
            bus.ram_wdata  = bus.dma_wdata;
            rd_sel         = ~bus.dma_we;
            wr_sel         = bus.dma_we;
            bus.cpu_clk_en = ~core_acc;
        end
    end

    // DMA read data is captured at the end of the S_DMA cycle and held
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset)                  bus.dma_rdata <= 4'd0;
        else if (dma_own && !bus.dma_we) bus.dma_rdata <= bus.ram_rdata;
    end

    // strobes confined to the clk-low half so one access completes per cycle
    assign bus.ram_nrd    = ~(rd_sel & ~clk);
    assign bus.ram_nwr    = ~(wr_sel & ~clk);
    assign bus.cpu_rdata  = bus.ram_rdata;
    assign bus.dma_ack    = (state == S_ACK);
    assign bus.dma_starve = starve;

endmodule

// File: tb/tb_hc4_ram_arbiter.sv
// tb_hc4_ram_arbiter: directed bench for hc4_ram_arbiter with a 256x4 RAM
// model that latches on the rising edge of ram_nwr. Inputs change 1 ns after
// the rising clock edge; outputs are sampled 1 ns after the falling edge,
// inside the strobe half. Starvation expectations follow HC4_ARB_FAIR_EN.
module tb_hc4_ram_arbiter;
    logic clk = 1'b0;
    logic nReset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   stalls;

    hc4_ram_arbiter_if bus ();

    hc4_ram_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // RAM model: asynchronous read, write latched on ram_nwr rising edge
    logic [3:0] mem [0:255];
    logic [7:0] wa;
    logic [3:0] wd;
    assign bus.ram_rdata = mem[bus.ram_addr];
    always @(negedge clk) begin
        #1;
        if (!bus.ram_nwr) begin
            wa <= bus.ram_addr;
            wd <= bus.ram_wdata;
        end
    end
    always @(posedge bus.ram_nwr) mem[wa] <= wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    task automatic idle_all();
        bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = 8'h77; bus.cpu_wdata = 4'h0;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = 8'h00; bus.dma_wdata = 4'h0;
    endtask

    // one DMA access with the core idle: ack expected two cycles after request
    task automatic dma_do(input string tag, input logic we, input logic [7:0] a,
                          input logic [3:0] d, input logic [3:0] exp_rd);
        cyc();
        bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
        mid(); chk({tag, "_ack_n"}, bus.dma_ack, 0);
        cyc();
        mid(); chk({tag, "_ack_n1"}, bus.dma_ack, 0);
        chk({tag, "_addr"}, bus.ram_addr, a);
        chk({tag, "_strobe"}, {bus.ram_nrd, bus.ram_nwr}, we ? 2'b10 : 2'b01);
        chk({tag, "_clken"}, bus.cpu_clk_en, 1);
        cyc();
        bus.dma_req = 1'b0;
        mid(); chk({tag, "_ack_n2"}, bus.dma_ack, 1);
        if (!we) chk({tag, "_rdata"}, bus.dma_rdata, exp_rd);
    endtask

    initial begin
        idle_all();
        // reset state
        mid();
        chk("rst_ack", bus.dma_ack, 0);
        chk("rst_rdata", bus.dma_rdata, 0);
        chk("rst_starve", bus.dma_starve, 0);
        chk("rst_clken", bus.cpu_clk_en, 1);
        chk("rst_strobes", {bus.ram_nrd, bus.ram_nwr}, 2'b11);
        chk("rst_addr", bus.ram_addr, 8'h77);
        cyc(); nReset = 1'b1;

        // core idle: DMA write then read back
        dma_do("dwr10", 1'b1, 8'h10, 4'h5, 4'h0);
        dma_do("drd10", 1'b0, 8'h10, 4'h0, 4'h5);
        dma_do("pre20", 1'b1, 8'h20, 4'h7, 4'h0);
        dma_do("pre30", 1'b1, 8'h30, 4'h9, 4'h0);

        // core reads 0x20 every cycle while a DMA read of 0x30 is pending
        stalls = 0;
        cyc();
        bus.cpu_rd = 1'b1; bus.cpu_addr = 8'h20;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 8'h30;
`ifdef HC4_ARB_FAIR_EN
        for (int i = 1; i <= 4; i++) begin
            mid();
            chk("fair_wait_starve", bus.dma_starve, 0);
            chk("fair_wait_rdata", bus.cpu_rdata, 4'h7);
            chk("fair_wait_nrd", bus.ram_nrd, 0);
            stalls += !bus.cpu_clk_en;
            cyc();
        end
        mid();
        chk("fair_starve", bus.dma_starve, 1);
        chk("fair_starve_nrd", bus.ram_nrd, 1);
        stalls += !bus.cpu_clk_en;
        cyc();
        mid();
        chk("fair_dma_addr", bus.ram_addr, 8'h30);
        chk("fair_dma_ack", bus.dma_ack, 0);
        stalls += !bus.cpu_clk_en;
        cyc();
        bus.dma_req = 1'b0;
        mid();
        chk("fair_ack", bus.dma_ack, 1);
        chk("fair_dma_rdata", bus.dma_rdata, 4'h9);
        chk("fair_core_rdata", bus.cpu_rdata, 4'h7);
        stalls += !bus.cpu_clk_en;
        chk("fair_stalls", stalls, 2);
`else
        for (int i = 1; i <= 8; i++) begin
            mid();
            chk("strict_no_ack", bus.dma_ack, 0);
            chk("strict_starve", bus.dma_starve, 0);
            chk("strict_rdata", bus.cpu_rdata, 4'h7);
            stalls += !bus.cpu_clk_en;
            cyc();
        end
        chk("strict_stalls", stalls, 0);
        bus.cpu_rd = 1'b0;
        mid(); chk("strict_ack_c0", bus.dma_ack, 0);
        cyc();
        mid(); chk("strict_ack_c1", bus.dma_ack, 0);
        chk("strict_dma_addr", bus.ram_addr, 8'h30);
        cyc();
        bus.dma_req = 1'b0;
        mid(); chk("strict_ack_c2", bus.dma_ack, 1);
        chk("strict_dma_rdata", bus.dma_rdata, 4'h9);
`endif
        cyc(); idle_all();

        // core write collides with a DMA write to the same address
        cyc();
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 8'h01; bus.dma_wdata = 4'h3;
        mid(); chk("col_ack0", bus.dma_ack, 0);
        cyc();
        bus.cpu_wr = 1'b1; bus.cpu_addr = 8'h01; bus.cpu_wdata = 4'hA;
        mid();
        chk("col_stall", bus.cpu_clk_en, 0);
        chk("col_dma_wdata", bus.ram_wdata, 4'h3);
        chk("col_dma_nwr", bus.ram_nwr, 0);
        cyc();
        bus.dma_req = 1'b0;
        mid();
        chk("col_ack", bus.dma_ack, 1);
        chk("col_run", bus.cpu_clk_en, 1);
        chk("col_cpu_wdata", bus.ram_wdata, 4'hA);
        chk("col_cpu_nwr", bus.ram_nwr, 0);
        cyc(); idle_all();
        mid(); chk("col_mem01", mem[8'h01], 4'hA);

        // decode error: read and write together, write wins
        cyc();
        bus.cpu_rd = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_addr = 8'h02; bus.cpu_wdata = 4'h6;
        mid(); chk("rw_strobes", {bus.ram_nrd, bus.ram_nwr}, 2'b10);
        cyc(); idle_all();
        mid(); chk("rw_mem02", mem[8'h02], 4'h6);

        // back-to-back requests, next one presented during the ack cycle
        cyc();
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 8'h50; bus.dma_wdata = 4'h1;
        mid(); chk("b2b_c0", bus.dma_ack, 0);
        cyc();
        mid(); chk("b2b_c1", bus.dma_ack, 0);
        cyc();
        bus.dma_addr = 8'h51; bus.dma_wdata = 4'h2;
        mid(); chk("b2b_ack1", bus.dma_ack, 1);
        cyc();
        mid(); chk("b2b_c3", bus.dma_ack, 0);
        chk("b2b_c3_nwr", bus.ram_nwr, 1);
        cyc();
        mid(); chk("b2b_c4", bus.dma_ack, 0);
        chk("b2b_c4_addr", bus.ram_addr, 8'h51);
        chk("b2b_c4_nwr", bus.ram_nwr, 0);
        cyc();
        bus.dma_req = 1'b0;
        mid(); chk("b2b_ack2", bus.dma_ack, 1);
        cyc();
        mid();
        chk("b2b_mem50", mem[8'h50], 4'h1);
        chk("b2b_mem51", mem[8'h51], 4'h2);

        // reset while a DMA write to 0x42 is in S_DMA
        dma_do("pre42", 1'b1, 8'h42, 4'h0, 4'h0);
        cyc();
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 8'h42; bus.dma_wdata = 4'hF;
        mid(); chk("rstd_ack0", bus.dma_ack, 0);
        cyc();
        nReset = 1'b0;
        mid();
        chk("rstd_nwr", bus.ram_nwr, 1);
        chk("rstd_clken", bus.cpu_clk_en, 1);
        chk("rstd_ack", bus.dma_ack, 0);
        chk("rstd_addr", bus.ram_addr, 8'h77);
        chk("rstd_rdata", bus.dma_rdata, 0);
        cyc();
        bus.dma_req = 1'b0; nReset = 1'b1;
        mid(); chk("rstd_ack1", bus.dma_ack, 0);
        cyc();
        mid(); chk("rstd_ack2", bus.dma_ack, 0);
        chk("rstd_mem42", mem[8'h42], 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // hard stop in case the sequence above ever stalls
    initial begin
        #20000;
        $display("FAIL timeout: got stalled want finished");
        $fatal(1, "timeout");
    end
endmodule
